// File: rtl/keypad_matrix_scanner.sv
// Keypad matrix scanner: one-hot column strobe, debounced single-key detection,
// linear key index with one-cycle valid pulse and multi-key error pulse.
module keypad_matrix_scanner #(
    parameter  int ROWS     = 4,
    parameter  int COLS     = 4,
    parameter  int SCAN_DIV = 2500,
    parameter  int DEBOUNCE = 20,
    localparam int CODE_W   = $clog2(ROWS * COLS)
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic [ROWS-1:0]   row_i,
    output logic [COLS-1:0]   col_o,
    output logic [CODE_W-1:0] key_code,
    output logic              key_valid,
    output logic              key_held,
    output logic              multi_err
);

    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam int COL_W = $clog2(COLS);
    localparam int ROW_W = $clog2(ROWS);
    localparam int DB_W  = $clog2(DEBOUNCE + 1);

    typedef enum logic [1:0] {
        ST_SCAN,
        ST_DEBOUNCE,
        ST_HELD,
        ST_RELEASE
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [COL_W-1:0]    col_idx_q, col_idx_d;
    logic [ROW_W-1:0]    row_idx_q, row_idx_d;
    logic [DB_W-1:0]     dbcnt_q, dbcnt_d;
    logic [COLS-1:0]     col_o_q, col_o_d;
    logic [CODE_W-1:0]   key_code_q, key_code_d;
    logic                key_valid_q, key_valid_d;
    logic                key_held_q, key_held_d;
    logic                multi_err_q, multi_err_d;

    logic                tick;
    logic [COL_W-1:0]    col_next;
    logic [ROW_W-1:0]    hit_row;
    logic [ROWS-1:0]     cap_oh;
    logic                cap_bit;

    always_comb begin
        tick     = (cnt_q == CNT_W'(SCAN_DIV - 1));
        cnt_d    = tick ? '0 : cnt_q + 1'b1;
        col_next = (col_idx_q == COL_W'(COLS - 1)) ? '0 : col_idx_q + 1'b1;
        cap_oh   = ROWS'(1) << row_idx_q;
        cap_bit  = row_i[row_idx_q];
        hit_row  = '0;
        for (int unsigned i = 0; i < ROWS; i++) begin
            if (row_i[i]) hit_row = ROW_W'(i);
        end

        state_d     = state_q;
        col_idx_d   = col_idx_q;
        row_idx_d   = row_idx_q;
        dbcnt_d     = dbcnt_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        multi_err_d = 1'b0;

        if (tick) begin
            case (state_q)
                ST_SCAN: begin
                    if ($onehot(row_i)) begin
                        row_idx_d = hit_row;
                        dbcnt_d   = '0;
                        state_d   = ST_DEBOUNCE;
                    end else begin
                        multi_err_d = ($countones(row_i) > 1);
                        col_idx_d   = col_next;
                    end
                end
                ST_DEBOUNCE: begin
                    if (row_i == cap_oh) begin
                        if (dbcnt_q == DB_W'(DEBOUNCE - 1)) begin
                            key_code_d  = CODE_W'(col_idx_q) * CODE_W'(ROWS) + CODE_W'(row_idx_q);
                            key_valid_d = 1'b1;
                            state_d     = ST_HELD;
                        end else begin
                            dbcnt_d = dbcnt_q + 1'b1;
                        end
                    end else begin
                        state_d   = ST_SCAN;
                        col_idx_d = col_next;
                    end
                end
                ST_HELD: begin
                    // Only the captured row matters; other keys in this column are ignored.
                    if (!cap_bit) begin
                        dbcnt_d = '0;
                        state_d = ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    if (!cap_bit) begin
                        if (dbcnt_q == DB_W'(DEBOUNCE - 1)) begin
                            state_d   = ST_SCAN;
                            col_idx_d = col_next;
                        end else begin
                            dbcnt_d = dbcnt_q + 1'b1;
                        end
                    end else begin
                        dbcnt_d = '0;
                        state_d = ST_HELD;
                    end
                end
                default: state_d = ST_SCAN;
            endcase
        end

        key_held_d = (state_d == ST_HELD) || (state_d == ST_RELEASE);
        col_o_d    = COLS'(1) << col_idx_d;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q     <= ST_SCAN;
            cnt_q       <= '0;
            col_idx_q   <= '0;
            row_idx_q   <= '0;
            dbcnt_q     <= '0;
            col_o_q     <= COLS'(1);
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
            multi_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            col_idx_q   <= col_idx_d;
            row_idx_q   <= row_idx_d;
            dbcnt_q     <= dbcnt_d;
            col_o_q     <= col_o_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
            multi_err_q <= multi_err_d;
        end
    end

    assign col_o     = col_o_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;
    assign multi_err = multi_err_q;

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Directed bench for keypad_matrix_scanner (4x4, SCAN_DIV=4, DEBOUNCE=3) with a
// key-matrix model driving row_i and a queue of expected accepted key codes.
module tb_keypad_matrix_scanner;

    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int SDIV = 4;
    localparam int DEB  = 3;
    localparam int CW   = $clog2(ROWS * COLS);

    logic            clk;
    logic            nrst;
    logic [ROWS-1:0] row_i;
    logic [COLS-1:0] col_o;
    logic [CW-1:0]   key_code;
    logic            key_valid;
    logic            key_held;
    logic            multi_err;

    logic [ROWS*COLS-1:0] keys;
    int unsigned total;
    int unsigned bad;
    int unsigned merr_seen;
    int unsigned merr_exp;
    logic        prev_valid;
    logic        prev_merr;
    logic [CW-1:0] exp_q[$];

    keypad_matrix_scanner #(
        .ROWS(ROWS),
        .COLS(COLS),
        .SCAN_DIV(SDIV),
        .DEBOUNCE(DEB)
    ) dut (
        .clk(clk),
        .nrst(nrst),
        .row_i(row_i),
        .col_o(col_o),
        .key_code(key_code),
        .key_valid(key_valid),
        .key_held(key_held),
        .multi_err(multi_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Closed key at (col c, row r) pulls row r high while column c is driven.
    always_comb begin
        row_i = '0;
        for (int c = 0; c < COLS; c++) begin
            if (col_o[c]) row_i = row_i | keys[c*ROWS +: ROWS];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ticks(input int n);
        repeat (n * SDIV) @(negedge clk);
    endtask

    // Output monitor: pops the scoreboard on every key_valid, checks pulse widths.
    always @(negedge clk) begin
        if (nrst) begin
            check("col_onehot", 32'($onehot(col_o)), 32'd1);
            if (key_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_key_valid", 32'(key_code), 32'hFFFF_FFFF);
                end else begin
                    check("key_code_at_valid", 32'(key_code), 32'(exp_q.pop_front()));
                end
                if (prev_valid) check("key_valid_width", 32'd2, 32'd1);
            end
            if (multi_err) begin
                merr_seen++;
                if (prev_merr) check("multi_err_width", 32'd2, 32'd1);
            end
        end
        prev_valid = key_valid;
        prev_merr  = multi_err;
    end

    initial begin
        total = 0; bad = 0; merr_seen = 0; merr_exp = 0;
        prev_valid = 1'b0; prev_merr = 1'b0;
        keys = '0;
        nrst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_col_o", 32'(col_o), 32'h1);
        check("rst_key_code", 32'(key_code), 32'h0);
        check("rst_key_valid", 32'(key_valid), 32'h0);
        check("rst_key_held", 32'(key_held), 32'h0);
        check("rst_multi_err", 32'(multi_err), 32'h0);
        nrst = 1'b1;

        // 1: idle scan, column changes every SCAN_DIV clocks and wraps
        for (int k = 0; k < 20; k++) begin
            check("idle_col_o", 32'(col_o), 32'(1 << ((k / SDIV) % COLS)));
            check("idle_key_valid", 32'(key_valid), 32'h0);
            @(negedge clk);
        end

        // 2: clean press of key 6 (col1,row2)
        check("t2_start_col", 32'(col_o), 32'h2);
        keys[6] = 1'b1;
        wait_ticks(1);
        check("t2_frozen_col", 32'(col_o), 32'h2);
        wait_ticks(DEB - 1);
        check("t2_no_early_valid", 32'(key_valid), 32'h0);
        check("t2_not_held_yet", 32'(key_held), 32'h0);
        exp_q.push_back(CW'(6));
        wait_ticks(1);
        check("t2_valid", 32'(key_valid), 32'h1);
        check("t2_code", 32'(key_code), 32'd6);
        check("t2_held", 32'(key_held), 32'h1);
        check("t2_col_frozen", 32'(col_o), 32'h2);
        keys[6] = 1'b0;
        wait_ticks(1 + DEB);
        check("t2_released", 32'(key_held), 32'h0);
        check("t2_col_after_rel", 32'(col_o), 32'h4);

        // 3: bounce during debounce aborts the press
        wait_ticks(3);
        check("t3_start_col", 32'(col_o), 32'h2);
        keys[6] = 1'b1;
        wait_ticks(2);
        keys[6] = 1'b0;
        wait_ticks(1);
        check("t3_col_resumed", 32'(col_o), 32'h4);
        check("t3_not_held", 32'(key_held), 32'h0);
        check("t3_code_kept", 32'(key_code), 32'd6);

        // 4: two keys in column 1 -> multi_err, column advances
        wait_ticks(3);
        check("t4_start_col", 32'(col_o), 32'h2);
        keys[4] = 1'b1; keys[5] = 1'b1;
        merr_exp++;
        wait_ticks(1);
        check("t4_multi_err", 32'(multi_err), 32'h1);
        check("t4_col_adv", 32'(col_o), 32'h4);
        check("t4_not_held", 32'(key_held), 32'h0);
        keys[4] = 1'b0; keys[5] = 1'b0;

        // 5: held key with release rebound, then clean release
        wait_ticks(3);
        check("t5_start_col", 32'(col_o), 32'h2);
        keys[6] = 1'b1;
        exp_q.push_back(CW'(6));
        wait_ticks(1 + DEB);
        check("t5_valid", 32'(key_valid), 32'h1);
        check("t5_code", 32'(key_code), 32'd6);
        keys[6] = 1'b0;
        wait_ticks(2);
        keys[6] = 1'b1;
        wait_ticks(1);
        check("t5_rebound_held", 32'(key_held), 32'h1);
        check("t5_rebound_col", 32'(col_o), 32'h2);
        keys[6] = 1'b0;
        wait_ticks(DEB);
        check("t5_still_held", 32'(key_held), 32'h1);
        wait_ticks(1);
        check("t5_released", 32'(key_held), 32'h0);
        check("t5_col_after_rel", 32'(col_o), 32'h4);
        check("t5_code_kept", 32'(key_code), 32'd6);

        // 6: asynchronous reset mid-debounce
        wait_ticks(3);
        check("t6_start_col", 32'(col_o), 32'h2);
        keys[6] = 1'b1;
        wait_ticks(2);
        #2 nrst = 1'b0;
        #1;
        check("t6_rst_col", 32'(col_o), 32'h1);
        check("t6_rst_code", 32'(key_code), 32'h0);
        check("t6_rst_valid", 32'(key_valid), 32'h0);
        check("t6_rst_held", 32'(key_held), 32'h0);
        check("t6_rst_merr", 32'(multi_err), 32'h0);
        repeat (2) @(negedge clk);
        nrst = 1'b1;
        wait_ticks(1 + DEB);
        check("t6_no_stale_valid", 32'(key_valid), 32'h0);
        check("t6_no_stale_held", 32'(key_held), 32'h0);
        exp_q.push_back(CW'(6));
        wait_ticks(1);
        check("t6_new_press_valid", 32'(key_valid), 32'h1);
        check("t6_new_press_code", 32'(key_code), 32'd6);
        keys[6] = 1'b0;
        repeat (2) @(negedge clk);

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        check("multi_err_count", merr_seen, merr_exp);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
